loop_cnt: RTL and testbench

- Parametrised successor to the team's load/decrement counter; adds reset, direction, step size and a terminal limit.
- Adds a start/busy/done handshake so a datapath controller (e.g. the factorial multiply loop) can launch a counted loop and wait for completion.
- Optional auto-reload gives a periodic tick source.
- Sits between the control FSM and the datapath.

---
 rtl/loop_cnt_pkg.sv | 14 +
 rtl/loop_cnt_step.sv | 30 +++
 rtl/loop_cnt.sv | 106 ++++++++++
 tb/tb_loop_cnt.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/loop_cnt_pkg.sv
// Shared definitions for the loop counter: state encoding used by the control FSM.
package loop_cnt_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/loop_cnt_step.sv
// Combinational step/terminal evaluation for loop_cnt: one count step computed
// with a spare top bit so any wrap past 0 or 2**SIZE-1 shows up as terminal.
module loop_cnt_step #(
    parameter int SIZE   = 8,
    parameter int STEP_W = 4
) (
    input  logic [SIZE-1:0]   q,
    input  logic [STEP_W-1:0] step_r,
    input  logic [SIZE-1:0]   lim_r,
    input  logic              dir,
    output logic [SIZE-1:0]   nxt_q,
    output logic              term
);

    logic [SIZE:0] q_x;
    logic [SIZE:0] step_x;
    logic [SIZE:0] lim_x;
    logic [SIZE:0] nxt;

    assign q_x    = {1'b0, q};
    assign step_x = {{(SIZE + 1 - STEP_W){1'b0}}, step_r};
    assign lim_x  = {1'b0, lim_r};

    assign nxt = dir ? (q_x + step_x) : (q_x - step_x);

    // Down: the top bit set means a borrow, which is always terminal.
    assign term  = dir ? (nxt >= lim_x) : (nxt[SIZE] || (nxt <= lim_x));
    assign nxt_q = nxt[SIZE-1:0];

endmodule

// File: rtl/loop_cnt.sv
// Loop counter with start/busy/done handshake, direction, step, clamped terminal
// limit and optional auto-reload for periodic operation.
module loop_cnt
    import loop_cnt_pkg::*;
#(
    parameter int SIZE        = 8,
    parameter int STEP_W      = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              abort,
    input  logic              up,
    input  logic [SIZE-1:0]   d,
    input  logic [SIZE-1:0]   lim,
    input  logic [STEP_W-1:0] step,
    output logic [SIZE-1:0]   q,
    output logic              busy,
    output logic              done
);

    state_t              state_reg, state_next;
    logic [SIZE-1:0]     q_reg, q_next;
    logic                dir_reg;
    logic [SIZE-1:0]     lim_reg;
    logic [STEP_W-1:0]   step_reg;
    logic                load_cfg;
    logic [SIZE-1:0]     nxt_q;
    logic                term;

    loop_cnt_step #(
        .SIZE   (SIZE),
        .STEP_W (STEP_W)
    ) u_step (
        .q      (q_reg),
        .step_r (step_reg),
        .lim_r  (lim_reg),
        .dir    (dir_reg),
        .nxt_q  (nxt_q),
        .term   (term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            q_reg     <= '0;
            dir_reg   <= 1'b1;
            lim_reg   <= '0;
            step_reg  <= STEP_W'(1);
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            if (load_cfg) begin
                dir_reg  <= up;
                lim_reg  <= lim;
                step_reg <= (step == '0) ? STEP_W'(1) : step;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        load_cfg   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                    q_next     = d;
                    load_cfg   = 1'b1;
                end
            end
            S_RUN: begin
                // abort outranks both en and a terminal step
                if (abort) begin
                    state_next = S_IDLE;
                end else if (en) begin
                    if (term) begin
                        q_next     = lim_reg;
                        state_next = S_DONE;
                    end else begin
                        q_next = nxt_q;
                    end
                end
            end
            S_DONE: begin
                if (abort || !AUTO_RELOAD) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_RUN;
                    q_next     = d;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign q    = q_reg;
    assign busy = (state_reg == S_RUN);
    assign done = (state_reg == S_DONE);

endmodule

// File: tb/tb_loop_cnt.sv
// Bench for loop_cnt: directed vector table, hand sequences for reset/auto-reload/abort,
// and randomized traffic against an integer-arithmetic reference model.
module tb_loop_cnt;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       start0, start1;
    logic       abort0, abort1;
    logic       up;
    logic [7:0] d, lim;
    logic [3:0] step;
    logic [7:0] q0, q1;
    logic       busy0, busy1, done0, done1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    loop_cnt #(.SIZE(8), .STEP_W(4), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .start(start0), .abort(abort0), .up(up),
        .d(d), .lim(lim), .step(step), .q(q0), .busy(busy0), .done(done0)
    );

    loop_cnt #(.SIZE(8), .STEP_W(4), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .start(start1), .abort(abort1), .up(up),
        .d(d), .lim(lim), .step(step), .q(q1), .busy(busy1), .done(done1)
    );

    typedef struct {
        bit         start;
        bit         en;
        bit         abort;
        bit         up;
        logic [7:0] d;
        logic [7:0] lim;
        logic [3:0] step;
        int         eq;
        bit         eb;
        bit         ed;
    } vec_t;

    // phase: 0 idle, 1 counting, 2 finished
    typedef struct {
        int phase;
        int q;
        bit dir;
        int lim;
        int step;
    } mdl_t;

    vec_t tbl [0:32];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string name, input int eq, input int eb, input int ed);
        chk({name, "_q"}, int'(q0), eq);
        chk({name, "_busy"}, int'(busy0), eb);
        chk({name, "_done"}, int'(done0), ed);
        $display("dut0 %s q=%0d busy=%0d done=%0d", name, q0, busy0, done0);
    endtask

    task automatic chk1(input string name, input int eq, input int eb, input int ed);
        chk({name, "_q"}, int'(q1), eq);
        chk({name, "_busy"}, int'(busy1), eb);
        chk({name, "_done"}, int'(done1), ed);
        $display("dut1 %s q=%0d busy=%0d done=%0d", name, q1, busy1, done1);
    endtask

    // Reference: plain signed integer arithmetic, terminal when the limit is reached or passed.
    function automatic mdl_t mstep(input mdl_t s, input bit reload, input bit st, input bit ab,
                                   input bit en_i, input bit up_i, input int d_i,
                                   input int lim_i, input int step_i);
        mdl_t n = s;
        int   nx;
        if (s.phase == 0) begin
            if (st) begin
                n.phase = 1;
                n.q     = d_i;
                n.dir   = up_i;
                n.lim   = lim_i;
                n.step  = (step_i == 0) ? 1 : step_i;
            end
        end else if (s.phase == 1) begin
            if (ab) begin
                n.phase = 0;
            end else if (en_i) begin
                nx = s.dir ? s.q + s.step : s.q - s.step;
                if (s.dir ? (nx >= s.lim) : (nx <= s.lim)) begin
                    n.q     = s.lim;
                    n.phase = 2;
                end else begin
                    n.q = nx;
                end
            end
        end else begin
            if (reload && !ab) begin
                n.phase = 1;
                n.q     = d_i;
            end else begin
                n.phase = 0;
            end
        end
        return n;
    endfunction

    initial begin
        mdl_t m0, m1, n0, n1;
        int   ar_q [0:7];
        int   ar_b [0:7];
        int   ar_d [0:7];

        //            st en ab up   d    lim  step  q   b  d
        tbl[0]  = '{1, 1, 0, 1,   3,   7, 2,    3,  1, 0};
        tbl[1]  = '{0, 1, 0, 1,   3,   7, 2,    5,  1, 0};
        tbl[2]  = '{0, 1, 0, 1,   3,   7, 2,    7,  0, 1};
        tbl[3]  = '{0, 1, 0, 1,   3,   7, 2,    7,  0, 0};
        tbl[4]  = '{1, 1, 0, 0,  10,   0, 3,   10,  1, 0};
        tbl[5]  = '{0, 1, 0, 0,  10,   0, 3,    7,  1, 0};
        tbl[6]  = '{0, 0, 0, 0,  10,   0, 3,    7,  1, 0};
        tbl[7]  = '{0, 1, 0, 0,  10,   0, 3,    4,  1, 0};
        tbl[8]  = '{0, 0, 0, 0,  10,   0, 3,    4,  1, 0};
        tbl[9]  = '{0, 1, 0, 0,  10,   0, 3,    1,  1, 0};
        tbl[10] = '{0, 0, 0, 0,  10,   0, 3,    1,  1, 0};
        tbl[11] = '{0, 1, 0, 0,  10,   0, 3,    0,  0, 1};
        tbl[12] = '{0, 0, 0, 0,  10,   0, 3,    0,  0, 0};
        tbl[13] = '{1, 1, 0, 1, 250, 255, 8,  250,  1, 0};
        tbl[14] = '{0, 1, 0, 1, 250, 255, 8,  255,  0, 1};
        tbl[15] = '{0, 1, 0, 1, 250, 255, 8,  255,  0, 0};
        tbl[16] = '{1, 1, 0, 1,   5,   5, 1,    5,  1, 0};
        tbl[17] = '{0, 1, 0, 1,   5,   5, 1,    5,  0, 1};
        tbl[18] = '{0, 1, 0, 1,   5,   5, 1,    5,  0, 0};
        tbl[19] = '{1, 1, 0, 1,   0,   3, 0,    0,  1, 0};
        tbl[20] = '{0, 1, 0, 1,   0,   3, 0,    1,  1, 0};
        tbl[21] = '{0, 1, 0, 1,   0,   3, 0,    2,  1, 0};
        tbl[22] = '{0, 1, 0, 1,   0,   3, 0,    3,  0, 1};
        tbl[23] = '{0, 1, 0, 1,   0,   3, 0,    3,  0, 0};
        tbl[24] = '{1, 1, 0, 1,   0,   4, 2,    0,  1, 0};
        tbl[25] = '{1, 1, 0, 0, 100, 200, 1,    2,  1, 0};
        tbl[26] = '{1, 1, 0, 0, 100, 200, 1,    4,  0, 1};
        tbl[27] = '{1, 1, 0, 1, 100, 200, 1,    4,  0, 0};
        tbl[28] = '{0, 1, 0, 1, 100, 200, 1,    4,  0, 0};
        tbl[29] = '{1, 1, 0, 1,  20,  30, 1,   20,  1, 0};
        tbl[30] = '{0, 1, 1, 1,  20,  30, 1,   20,  0, 0};
        tbl[31] = '{1, 1, 1, 1,   9,   9, 1,    9,  1, 0};
        tbl[32] = '{0, 1, 1, 1,   9,   9, 1,    9,  0, 0};

        rst = 1'b1; en = 1'b0; up = 1'b0;
        start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
        d = '0; lim = '0; step = '0;
        #3;
        chk0("reset", 0, 0, 0);
        chk1("reset", 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 33; i++) begin
            start0 = tbl[i].start; en = tbl[i].en; abort0 = tbl[i].abort; up = tbl[i].up;
            d = tbl[i].d; lim = tbl[i].lim; step = tbl[i].step;
            tick();
            chk0($sformatf("vec%0d", i), tbl[i].eq, int'(tbl[i].eb), int'(tbl[i].ed));
        end
        start0 = 1'b0; abort0 = 1'b0;

        // reset asserted between edges while counting
        start0 = 1'b1; up = 1'b1; d = 8'd0; lim = 8'd200; step = 4'd1; en = 1'b1;
        tick();
        start0 = 1'b0;
        tick(); tick(); tick();
        chk0("pre_rst", 3, 1, 0);
        #3 rst = 1'b1;
        #1 chk0("rst_async", 0, 0, 0);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk0($sformatf("post_rst%0d", i), 0, 0, 0);
        end

        // periodic auto-reload then abort mid-count
        ar_q = '{0, 1, 2, 0, 1, 2, 0, 1};
        ar_b = '{1, 1, 0, 1, 1, 0, 1, 1};
        ar_d = '{0, 0, 1, 0, 0, 1, 0, 0};
        start1 = 1'b1; up = 1'b1; d = 8'd0; lim = 8'd2; step = 4'd1; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            start1 = 1'b0;
            chk1($sformatf("reload%0d", i), ar_q[i], ar_b[i], ar_d[i]);
        end
        abort1 = 1'b1;
        tick();
        chk1("abort", 1, 0, 0);
        abort1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1($sformatf("post_abort%0d", i), 1, 0, 0);
        end

        // randomized traffic on both instances against the reference model
        rst = 1'b1;
        #1 rst = 1'b0;
        m0 = '{0, 0, 1'b1, 0, 1};
        m1 = m0;
        for (int c = 0; c < 3000; c++) begin
            en     = ($urandom_range(0, 9) < 8);
            start0 = ($urandom_range(0, 9) < 2);
            start1 = ($urandom_range(0, 9) < 2);
            abort0 = ($urandom_range(0, 99) < 3);
            abort1 = ($urandom_range(0, 99) < 3);
            up     = 1'($urandom);
            d      = 8'($urandom);
            lim    = 8'($urandom);
            step   = 4'($urandom);
            n0 = mstep(m0, 1'b0, start0, abort0, en, up, int'(d), int'(lim), int'(step));
            n1 = mstep(m1, 1'b1, start1, abort1, en, up, int'(d), int'(lim), int'(step));
            tick();
            m0 = n0;
            m1 = n1;
            chk0($sformatf("rnd%0d", c), m0.q, int'(m0.phase == 1), int'(m0.phase == 2));
            chk1($sformatf("rnd%0d", c), m1.q, int'(m1.phase == 1), int'(m1.phase == 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
